// File: rtl/key_move_decoder.sv
// key_move_decoder: DE2 pushbuttons to Connect-4 moves.
// Debounced cursor with wrap, auto-repeat and drop handshake.
module key_move_decoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 7500000,
  parameter int NUM_COLS        = 7,
  parameter int START_COL       = 3
) (
  input  logic       clk,
  input  logic       clear_b,
  input  logic [3:0] KEY,
  input  logic       gameOver,
  input  logic       drop_ready,
  output logic [2:0] cursor_col,
  output logic       drop_valid,
  output logic [2:0] drop_col,
  output logic [3:0] key_state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);
  localparam logic [2:0] COL_MAX   = 3'(NUM_COLS - 1);
  localparam logic [2:0] COL_START = 3'(START_COL);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_t;

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    p;
  logic [3:0]    key_prev;
  logic [3:0]    press;
  logic [DW-1:0] cnt [4];

  rpt_t          state;
  rpt_t          nst;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] ncnt;
  logic          dir_r;
  logic          sdir;
  logic          step;
  logic          held;
  logic          both;
  logic [2:0]    col_r;
  logic [2:0]    col_l;

  // two-flop synchroniser; keys idle high (released)
  always_ff @(posedge clk) begin
    if (!clear_b) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  assign p = ~sync2;

  // per-key debounce: accept a level only after it holds long enough
  always_ff @(posedge clk) begin
    if (!clear_b) begin
      key_state <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (p[i] == key_state[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          key_state[i] <= ~key_state[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // previous debounced level, for rising-edge press pulses
  always_ff @(posedge clk) begin
    if (!clear_b) key_prev <= '0;
    else          key_prev <= key_state;
  end

  assign press = key_state & ~key_prev;
  assign held  = dir_r ? key_state[1] : key_state[2];
  assign both  = key_state[1] & key_state[2];
  assign col_r = (cursor_col == COL_MAX) ? 3'd0 : cursor_col + 3'd1;
  assign col_l = (cursor_col == 3'd0) ? COL_MAX : cursor_col - 3'd1;

  // repeat decision: which step, if any, happens this cycle
  always_comb begin
    step = 1'b0;
    sdir = dir_r;
    nst  = state;
    ncnt = '0;
    unique case (state)
      IDLE: begin
        if (press[1] & ~key_state[2]) begin
          step = 1'b1;
          sdir = 1'b1;
          nst  = DELAY;
        end else if (press[2] & ~key_state[1]) begin
          step = 1'b1;
          sdir = 1'b0;
          nst  = DELAY;
        end
      end
      DELAY: begin
        if (!held || both) begin
          nst = IDLE;
        end else if (rcnt == RD_LAST) begin
          step = 1'b1;
          nst  = REPEAT;
        end else begin
          ncnt = rcnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!held || both) begin
          nst = IDLE;
        end else if (rcnt == RR_LAST) begin
          step = 1'b1;
        end else begin
          ncnt = rcnt + 1'b1;
        end
      end
      default: nst = IDLE;
    endcase
  end

  // repeat state and cursor; recentre beats a step
  always_ff @(posedge clk) begin
    if (!clear_b) begin
      state      <= IDLE;
      rcnt       <= '0;
      dir_r      <= 1'b0;
      cursor_col <= COL_START;
    end else if (gameOver) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= nst;
      rcnt  <= ncnt;
      dir_r <= sdir;
      if (press[3]) begin
        cursor_col <= COL_START;
      end else if (step) begin
        cursor_col <= sdir ? col_r : col_l;
      end
    end
  end

  // drop request: one per press edge, held until accepted
  always_ff @(posedge clk) begin
    if (!clear_b) begin
      drop_valid <= 1'b0;
      drop_col   <= 3'd0;
    end else if (gameOver) begin
      drop_valid <= 1'b0;
    end else if (drop_valid) begin
      if (drop_ready) drop_valid <= 1'b0;
    end else if (press[0]) begin
      drop_valid <= 1'b1;
      drop_col   <= cursor_col;
    end
  end

endmodule

// File: doc/key_move_decoder.md
Name: key_move_decoder

Overview:
- Reads the DE2 pushbuttons and turns them into Connect-4 player moves. It drives the input side of the board, where led_sequencer drives the output side.
- Synchronises and debounces KEY[3:0] and keeps a cursor column (0..NUM_COLS-1), moved left/right with wrap and auto-repeat.
- Issues a valid/ready drop request carrying the cursor column to the game FSM.
- Ignores all input while the game is over.

Parameters:
- DEBOUNCE_CYCLES, 500000, clk cycles a raw key level must hold to be accepted (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles a left/right key is held before the first auto-repeat step.
- REPEAT_RATE, 7500000, cycles between later auto-repeat steps.
- NUM_COLS, 7, number of board columns; cursor range is 0..NUM_COLS-1.
- START_COL, 3, cursor value after reset and after a recentre.

Ports:
- clk  in  1  system clock, 50 MHz.
- clear_b  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- KEY  in  4  raw DE2 pushbuttons, active-low, asynchronous. KEY[0]=drop, KEY[1]=right, KEY[2]=left, KEY[3]=recentre.
- gameOver  in  1  high = game finished; all key actions are suppressed.
- drop_ready  in  1  game FSM accepts the drop request this cycle.
- cursor_col  out  3  current cursor column.
- drop_valid  out  1  a drop request is pending.
- drop_col  out  3  column of the pending drop; stable while drop_valid=1.
- key_state  out  4  debounced key levels, active-high (1 = pressed).

Behaviour:
- Reset (clear_b=0 at a clk edge), all registers set at that edge:
  - cursor_col=START_COL, drop_valid=0, drop_col=0, key_state=0.
  - Synchronisers load 1 (released); debounce and repeat counters clear.
  - Reset mid-operation discards any pending drop and any held-key state.
- Synchronise: each KEY bit passes through 2 flops. Press level p = ~sync.
- Debounce, per key:
  - Counter cnt resets to 0 whenever p equals key_state.
  - Otherwise cnt increments. When cnt reaches DEBOUNCE_CYCLES-1, key_state toggles and cnt clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - A glitch shorter than DEBOUNCE_CYCLES causes no change.
- Press event:
  - press[i] = key_state[i] rises (0->1), a 1-cycle pulse.
  - Latency from a clean raw edge to the press pulse: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Cursor step, evaluated only when gameOver=0:
  - Right step: cursor_col==NUM_COLS-1 ? 0 : cursor_col+1.
  - Left step: cursor_col==0 ? NUM_COLS-1 : cursor_col-1.
  - A step is applied on the cycle after its event.
  - Left and right both held (key_state[1]&key_state[2]=1): no step, and the repeat counter is held at 0.
  - Recentre press: cursor_col=START_COL. Recentre has priority over a left/right step in the same cycle.
- Auto-repeat, a single counter shared by left and right. States:
  - IDLE: on a press of exactly one of left/right -> step once, clear counter, go to DELAY.
  - DELAY: counter reaches REPEAT_DELAY-1 -> step, clear counter, go to REPEAT.
  - REPEAT: counter reaches REPEAT_RATE-1 -> step, clear counter, stay in REPEAT.
  - From any state: the held key releases, or the other direction key is also pressed -> IDLE.
- Drop handshake:
  - Drop press with gameOver=0 and drop_valid=0 -> next cycle drop_valid=1 and drop_col=cursor_col sampled at the press cycle.
  - drop_valid stays 1 and drop_col stays stable until a cycle with drop_ready=1. drop_valid clears on the following edge.
  - Drop press while drop_valid=1 is ignored; no queueing.
  - Holding the drop key never issues a second request; a new press edge is required.
  - Cursor may still move while a drop is pending; drop_col does not change.
  - Drop press and left/right step in the same cycle: drop_col takes the pre-step column.
- gameOver:
  - While gameOver=1, press events and repeat steps are discarded and the repeat FSM is forced to IDLE.
  - gameOver rising clears drop_valid on the next edge, even without drop_ready.
  - Debouncing continues, so key_state stays accurate.
  - cursor_col is held, not reset.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8):
- Reset: KEY=4'b1111, reset released -> cursor_col=3, drop_valid=0, key_state=0. Pull KEY[1] low for 3 cycles then release -> no change.
- Wrap: 3 clean right presses from 3 -> 4, 5, 6; a 4th -> 0. From 0, a left press -> 6.
- Auto-repeat: hold KEY[1] from cursor 0 for 50 cycles after debounce -> steps at +0, +20, +28, +36, +44, giving cursor 5. Release -> no further steps.
- Drop handshake: cursor 2, press KEY[0] with drop_ready=0 for 10 cycles -> drop_valid=1, drop_col=2. Move right meanwhile -> drop_col stays 2. Pulse drop_ready -> drop_valid=0 next cycle. A second press while pending -> ignored.
- Conflicts: hold left and right together -> cursor unchanged and no repeat. Recentre press together with a right press from 5 -> cursor 3.
- gameOver: drop pending, assert gameOver -> drop_valid=0 next cycle. Presses of all keys -> cursor and drop unchanged, key_state follows keys. Deassert gameOver and press drop -> drop_valid=1.
